// File: rtl/param_serializer.sv
// Parallel-to-serial frame engine: LANES-wide beats, optional even-parity trailer beat,
// and a one-word holding register so back-to-back frames run without idle gaps.
module param_serializer #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned LANES     = 1,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          PARITY_EN = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [LANES-1:0]  data_out_o,
  output logic              out_valid_o,
  output logic              frame_start_o,
  output logic              frame_end_o,
  output logic              busy_o
);

  localparam int unsigned Slices = DATA_W / LANES;
  localparam int unsigned Beats  = Slices + (PARITY_EN ? 1 : 0);
  localparam int unsigned CntW   = $clog2(Beats + 1);

  localparam logic [CntW-1:0] SlicesC = CntW'(Slices);
  localparam logic [CntW-1:0] BeatsC  = CntW'(Beats);
  localparam logic [CntW-1:0] OneC    = CntW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StPar
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [LANES-1:0]    dout_q, dout_d;
  logic                ovalid_q, ovalid_d;
  logic                fstart_q, fstart_d;
  logic                fend_q, fend_d;
  logic                par_q, par_d;
  logic [DATA_W-1:0]   hold_q, hold_d;
  logic                hold_vld_q, hold_vld_d;

  logic                accept;
  logic                start_new;
  logic [DATA_W-1:0]   new_word;
  logic [CntW-1:0]     cnt_inc;

  // Slice that goes out next from a word, honouring the configured slice order.
  function automatic logic [LANES-1:0] head_slice(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      return w[DATA_W-1 -: LANES];
    end
    return w[LANES-1:0];
  endfunction

  function automatic logic [DATA_W-1:0] advance(input logic [DATA_W-1:0] w);
    if (MSB_FIRST) begin
      return w << LANES;
    end
    return w >> LANES;
  endfunction

  assign in_ready_o = ~hold_vld_q & rst_n;
  assign accept     = in_valid_i & in_ready_o;
  assign cnt_inc    = cnt_q + OneC;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    par_d      = par_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    dout_d     = '0;
    ovalid_d   = 1'b0;
    fstart_d   = 1'b0;
    fend_d     = 1'b0;
    start_new  = 1'b0;
    new_word   = data_in_i;

    unique case (state_q)
      StIdle: begin
        start_new = accept;
      end
      StShift, StPar: begin
        if (fend_q) begin
          // Frame ends this cycle: chain the held word first, else a fresh acceptance.
          if (hold_vld_q) begin
            start_new  = 1'b1;
            new_word   = hold_q;
            hold_vld_d = 1'b0;
          end else if (accept) begin
            start_new = 1'b1;
          end else begin
            state_d = StIdle;
            cnt_d   = '0;
            shift_d = '0;
          end
        end else begin
          if (accept) begin
            hold_d     = data_in_i;
            hold_vld_d = 1'b1;
          end
          if (state_q == StShift && cnt_q < SlicesC) begin
            dout_d   = head_slice(shift_q);
            shift_d  = advance(shift_q);
            cnt_d    = cnt_inc;
            ovalid_d = 1'b1;
            fend_d   = (cnt_inc == BeatsC);
          end else if (PARITY_EN) begin
            state_d   = StPar;
            dout_d    = '0;
            dout_d[0] = par_q;
            cnt_d     = cnt_inc;
            ovalid_d  = 1'b1;
            fend_d    = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (start_new) begin
      state_d  = StShift;
      dout_d   = head_slice(new_word);
      shift_d  = advance(new_word);
      cnt_d    = OneC;
      par_d    = ^new_word;
      ovalid_d = 1'b1;
      fstart_d = 1'b1;
      fend_d   = (Beats == 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      shift_q    <= '0;
      cnt_q      <= '0;
      dout_q     <= '0;
      ovalid_q   <= 1'b0;
      fstart_q   <= 1'b0;
      fend_q     <= 1'b0;
      par_q      <= 1'b0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      cnt_q      <= cnt_d;
      dout_q     <= dout_d;
      ovalid_q   <= ovalid_d;
      fstart_q   <= fstart_d;
      fend_q     <= fend_d;
      par_q      <= par_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign data_out_o    = dout_q;
  assign out_valid_o   = ovalid_q;
  assign frame_start_o = fstart_q;
  assign frame_end_o   = fend_q;
  assign busy_o        = (state_q != StIdle) | hold_vld_q;

endmodule

// File: doc/param_serializer.md
PARAM_SERIALIZER -- requirements
Module: param_serializer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the parallel word width in bits.
REQ-002 The block SHALL have parameter LANES, default 1, giving the number of serial lanes; DATA_W SHALL be an integer multiple of LANES.
REQ-003 The block SHALL have parameter MSB_FIRST, default 1; 1 means the most-significant slice is sent first, 0 means the least-significant slice is sent first.
REQ-004 The block SHALL have parameter PARITY_EN, default 0; 1 appends one even-parity beat per frame.
REQ-005 Port clk, input, 1 bit: single clock; all state SHALL change on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port in_valid, input, 1 bit: data_in holds a word to send.
REQ-008 Port in_ready, output, 1 bit: the block can accept a word this cycle.
REQ-009 Port data_in, input, DATA_W bits: parallel word to send.
REQ-010 Port data_out, output, LANES bits: current serial slice, registered.
REQ-011 Port out_valid, output, 1 bit: data_out carries a frame beat, registered.
REQ-012 Port frame_start, output, 1 bit: high on the first beat of a frame only.
REQ-013 Port frame_end, output, 1 bit: high on the last beat of a frame only; this is the parity beat when PARITY_EN=1.
REQ-014 Port busy, output, 1 bit: a frame is in progress or a word is held.

Function
REQ-015 Beats per frame SHALL be N = DATA_W/LANES, plus 1 when PARITY_EN=1.
REQ-016 A word SHALL be accepted on a rising edge where in_valid and in_ready are both high.
REQ-017 The FSM SHALL have states IDLE, SHIFT and PAR; PAR is unreachable when PARITY_EN=0.
REQ-018 The IDLE state SHALL behave as follows:
- An accepted word SHALL be loaded into the shift register.
- The FSM SHALL move to SHIFT.
- The first beat SHALL appear on data_out in the next cycle (latency 1), with out_valid=1 and frame_start=1.
REQ-019 The SHIFT state SHALL behave as follows:
- It outputs one LANES-wide slice per cycle, in MSB_FIRST order.
- Each slice keeps its internal bit order: data_out[LANES-1] is the higher bit of the slice.
REQ-020 After the last data beat, the FSM SHALL go to PAR if PARITY_EN=1.
REQ-021 In PAR, data_out[0] SHALL be the XOR of all DATA_W bits, with all other lanes 0.
REQ-022 The block SHALL have a one-word holding register.
- in_ready SHALL equal NOT(holding register full) AND rst_n.
- Words SHALL be accepted while a frame is in progress.
REQ-023 At frame_end, if the holding register is full, its word SHALL start the next frame in the immediately following cycle with no idle gap, and the holding register SHALL empty.
REQ-024 At frame_end with the holding register empty but a simultaneous acceptance, the accepted word SHALL start the next frame in the following cycle without passing through the holding register.
REQ-025 At frame_end with no word available, the FSM SHALL return to IDLE.
REQ-026 In IDLE, data_out, out_valid, frame_start and frame_end SHALL be 0.
REQ-027 data_in SHALL be sampled only at acceptance; later changes to data_in SHALL NOT affect a frame in progress.
REQ-028 When N equals 1 beat (DATA_W=LANES, PARITY_EN=0), frame_start and frame_end SHALL both be high on the single beat.
REQ-029 The beat counter SHALL be ceil(log2(N+1)) bits wide and SHALL not wrap within a frame.
REQ-030 busy SHALL be 1 whenever the FSM is not in IDLE or the holding register is full.

Reset
REQ-031 While rst_n=0, all of the following SHALL be 0, asynchronously: data_out, out_valid, frame_start, frame_end, busy, in_ready, the shift register, the beat counter and the holding register valid flag.
REQ-032 While rst_n=0, the FSM SHALL be in IDLE.
REQ-033 Reset asserted mid-frame SHALL abort the frame and discard any held word; no partial beats SHALL follow reset release.
REQ-034 in_ready SHALL be 1 in the first cycle after rst_n rises.

Verification
REQ-035 Scenario 1, single lane:
- Setup: defaults; accept 32'hFE12_69FF.
- Required response: 32 beats with data_out = 1,1,1,1,1,1,1,0,0,0,0,1,... in MSB-first order.
- Required response: frame_start on beat 1 and frame_end on beat 32, then IDLE with outputs 0.
REQ-036 Scenario 2, four lanes:
- Setup: LANES=4; accept 32'hFE12_69FF.
- Required response: 8 beats of data_out = F,E,1,2,6,9,F,F.
- Required response with MSB_FIRST=0: 8 beats of data_out = F,F,9,6,2,1,E,F.
REQ-037 Scenario 3, parity:
- Setup: PARITY_EN=1, LANES=1; accept 32'hFE12_69FF (popcount 21).
- Required response: 33 beats, with beat 33 data_out=1 and frame_end=1.
- Required response for word 32'h0000_0003: beat 33 data_out=0.
REQ-038 Scenario 4, back-to-back frames:
- Setup: accept A=32'hFE12_69FF, then present B=32'h1234_5678 on the next cycle.
- Required response: B is held and in_ready=0 until the end of A.
- Required response: B's frame_start follows A's frame_end by exactly 1 cycle, and out_valid stays 1 throughout.
REQ-039 Scenario 5, reset mid-frame:
- Setup: drive rst_n=0 on beat 10 of a frame with B held.
- Required response: all outputs 0 immediately.
- Required response after release: in_ready=1, out_valid=0 and busy=0 until a new word is accepted.
